avg_sequencer: RTL and testbench
================================

# avg_sequencer

Moore-style control FSM that sequences the sample-averaging datapath: register file, ALU and the 10-bit sample counter. On each `data_ready` it loads the new sample, shifts a four-entry history, and accumulates the four-sample sum into R0. It also drives `cnt_up` to the sample counter and reports overflow errors. It sits between the external sample source and the datapath and is the only block that issues datapath operations.

## Interface
- No parameters: opcode map (NOP=0, COPY=1, LOAD=2, ADD=3) and register map (R0 sum, R1–R4 history, R5 new sample) are fixed.
- `clk`  in  1  system clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `data_ready`  in  1  new sample present on datapath input; level.
- `overflow`  in  1  ALU overflow flag of the current op, valid same cycle.
- `one_k_samples`  in  1  sample counter has reached 1000.
- `cnt_up`  out  1  one-cycle increment pulse to the sample counter.
- `clear`  out  1  one-cycle sample counter clear (see Configuration).
- `modwait`  out  1  sequencer busy.
- `op`  out  3  ALU/regfile opcode.
- `src1`, `src2`, `dest`  out  4 each  register addresses.
- `err`  out  1  sticky error indicator.

## Operation
- States and outputs. Outputs decode combinationally from the state register only; unlisted outputs are 0.
  - IDLE: op=NOP.
  - STORE: LOAD dest=5.
  - SH1: COPY src1=2 dest=1.
  - SH2: COPY src1=3 dest=2.
  - SH3: COPY src1=4 dest=3.
  - SH4: COPY src1=5 dest=4, cnt_up=1.
  - ADD1: ADD src1=1 src2=2 dest=0.
  - ADD2: ADD src1=0 src2=3 dest=0.
  - ADD3: ADD src1=0 src2=4 dest=0.
  - DONE: NOP.
  - EIDLE: NOP, err=1.
- `modwait`=1 in STORE through DONE; 0 in IDLE and EIDLE.
- Transitions:
  - IDLE→STORE when data_ready=1; else stay.
  - STORE→SH1 if data_ready=1, else →EIDLE (sample withdrawn).
  - SH1→SH2→SH3→SH4→ADD1 unconditionally.
  - ADDn→next state if overflow=0, else →EIDLE. ADD3's next state is DONE.
  - DONE→IDLE.
  - EIDLE→STORE when data_ready=1; else stay.
- The sum is unsigned; overflow detection is owned by the ALU; the sequencer only reacts to it.
- data_ready is ignored in SH1 through DONE. A sample arriving then is taken only if data_ready is still high in IDLE.

## Timing
- Reset (async assert): state=IDLE immediately. All outputs 0, including err, modwait and clear.
- Reset release takes effect at the next rising edge.
- Latency: data_ready seen high at edge k gives STORE in cycle k+1, cnt_up in cycle k+5, R0 valid after the ADD3 edge (k+8), and DONE in cycle k+9.
- modwait is high for 9 consecutive cycles on an error-free pass.
- data_ready held high continuously gives back-to-back passes: IDLE for 1 cycle between DONE and STORE, so a 10-cycle period.
- Overflow in ADDn: transition to EIDLE at that edge; err=1 the following cycle.
  - cnt_up has already fired for that sample, so the count is not rolled back.
- EIDLE with data_ready=1: err drops when entering STORE.
- Reset mid-pass: any state returns to IDLE asynchronously; no further cnt_up.

## Configuration
- `SAMPLE_CLEAR_EN` defined: in DONE, if one_k_samples=1, clear=1 for that single cycle. This wraps the sample counter after the 1000th sample.
- Undefined: clear is constant 0, and one_k_samples is unused (port kept).

## Test plan
- Reset: assert n_reset=0 mid-SH2 → state IDLE, modwait=0, op=0, err=0 without waiting for a clock edge.
- Single sample: data_ready=1 for 2 cycles, overflow=0 →
  - op/src1/src2/dest follow STORE(2,-,-,5), SH1(1,2,-,1) … ADD3(3,0,4,0);
  - cnt_up high exactly in cycle 5;
  - modwait high for 9 cycles.
- Withdrawn sample: data_ready=1 for 1 cycle only → STORE then EIDLE, err=1, cnt_up never pulses. A new data_ready=1 → STORE with err=0.
- Overflow: force overflow=1 during ADD2 → next cycle err=1, modwait=0, op=NOP. ADD3 and DONE never occur.
- Continuous input: data_ready held high for 3 passes → 3 cnt_up pulses spaced 10 cycles apart, with modwait low 1 cycle between passes.
- Wrap: with SAMPLE_CLEAR_EN, one_k_samples=1 → clear=1 only in DONE. Without the macro, clear stays 0 for the whole run.

Source files
------------

// File: rtl/avg_sequencer.sv
// Control FSM for the four-sample averaging datapath: load, history shift, sum into R0.
// Optional macro SAMPLE_CLEAR_EN: pulse clear in DONE when the sample counter reports 1000.
module avg_sequencer (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       data_ready,
    input  logic       overflow,
    input  logic       one_k_samples,
    output logic       cnt_up,
    output logic       clear,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_STORE = 4'd1;
    localparam logic [3:0] S_SH1   = 4'd2;
    localparam logic [3:0] S_SH2   = 4'd3;
    localparam logic [3:0] S_SH3   = 4'd4;
    localparam logic [3:0] S_SH4   = 4'd5;
    localparam logic [3:0] S_ADD1  = 4'd6;
    localparam logic [3:0] S_ADD2  = 4'd7;
    localparam logic [3:0] S_ADD3  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;
    localparam logic [3:0] S_EIDLE = 4'd10;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_COPY = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; overflow only matters during the ADD steps
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = data_ready ? S_STORE : S_IDLE;
            S_STORE: state_d = data_ready ? S_SH1 : S_EIDLE;
            S_SH1:   state_d = S_SH2;
            S_SH2:   state_d = S_SH3;
            S_SH3:   state_d = S_SH4;
            S_SH4:   state_d = S_ADD1;
            S_ADD1:  state_d = overflow ? S_EIDLE : S_ADD2;
            S_ADD2:  state_d = overflow ? S_EIDLE : S_ADD3;
            S_ADD3:  state_d = overflow ? S_EIDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_EIDLE: state_d = data_ready ? S_STORE : S_EIDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        op      = OP_NOP;
        src1    = 4'd0;
        src2    = 4'd0;
        dest    = 4'd0;
        cnt_up  = 1'b0;
        modwait = 1'b1;
        err     = 1'b0;
        case (state_q)
            S_IDLE:  modwait = 1'b0;
            S_STORE: begin op = OP_LOAD; dest = 4'd5; end
            S_SH1:   begin op = OP_COPY; src1 = 4'd2; dest = 4'd1; end
            S_SH2:   begin op = OP_COPY; src1 = 4'd3; dest = 4'd2; end
            S_SH3:   begin op = OP_COPY; src1 = 4'd4; dest = 4'd3; end
            S_SH4:   begin op = OP_COPY; src1 = 4'd5; dest = 4'd4; cnt_up = 1'b1; end
            S_ADD1:  begin op = OP_ADD; src1 = 4'd1; src2 = 4'd2; dest = 4'd0; end
            S_ADD2:  begin op = OP_ADD; src1 = 4'd0; src2 = 4'd3; dest = 4'd0; end
            S_ADD3:  begin op = OP_ADD; src1 = 4'd0; src2 = 4'd4; dest = 4'd0; end
            S_DONE:  op = OP_NOP;
            S_EIDLE: begin modwait = 1'b0; err = 1'b1; end
            default: modwait = 1'b0;
        endcase
    end

`ifdef SAMPLE_CLEAR_EN
    // Counter wrap after the 1000th sample
    always_comb begin
        if (state_q == S_DONE) begin
            clear = one_k_samples;
        end else begin
            clear = 1'b0;
        end
    end
`else
    logic unused_one_k_s;
    assign unused_one_k_s = one_k_samples;
    assign clear          = 1'b0;
`endif

endmodule

// File: tb/tb_avg_sequencer.sv
// Randomized and directed bench for avg_sequencer against a pass/step reference model.
module tb_avg_sequencer;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       data_ready = 1'b0;
    logic       overflow = 1'b0;
    logic       one_k_samples = 1'b0;
    logic       cnt_up, clear, modwait, err;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int cu_cycles[$];

    // Reference model: a pass is nine steps; outside a pass we are idle or in error
    bit m_busy = 1'b0;
    int m_step = 0;
    bit m_err  = 1'b0;

    int t_op[9] = '{2, 1, 1, 1, 1, 3, 3, 3, 0};
    int t_s1[9] = '{0, 2, 3, 4, 5, 1, 0, 0, 0};
    int t_s2[9] = '{0, 0, 0, 0, 0, 2, 3, 4, 0};
    int t_d [9] = '{5, 1, 2, 3, 4, 0, 0, 0, 0};

    avg_sequencer dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .data_ready    (data_ready),
        .overflow      (overflow),
        .one_k_samples (one_k_samples),
        .cnt_up        (cnt_up),
        .clear         (clear),
        .modwait       (modwait),
        .op            (op),
        .src1          (src1),
        .src2          (src2),
        .dest          (dest),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cycle, got, exp);
        end
    endtask

    task automatic compare_outputs();
        int e_clr;
        e_clr = 0;
`ifdef SAMPLE_CLEAR_EN
        if (m_busy && m_step == 8 && one_k_samples) e_clr = 1;
`endif
        check_val("op",      int'(op),      m_busy ? t_op[m_step] : 0);
        check_val("src1",    int'(src1),    m_busy ? t_s1[m_step] : 0);
        check_val("src2",    int'(src2),    m_busy ? t_s2[m_step] : 0);
        check_val("dest",    int'(dest),    m_busy ? t_d[m_step] : 0);
        check_val("cnt_up",  int'(cnt_up),  (m_busy && m_step == 4) ? 1 : 0);
        check_val("modwait", int'(modwait), m_busy ? 1 : 0);
        check_val("err",     int'(err),     (!m_busy && m_err) ? 1 : 0);
        check_val("clear",   int'(clear),   e_clr);
        if (cnt_up) cu_cycles.push_back(cycle);
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (data_ready) begin m_busy = 1'b1; m_step = 0; m_err = 1'b0; end
        end else if (m_step == 0 && !data_ready) begin
            m_busy = 1'b0; m_err = 1'b1;
        end else if (m_step >= 5 && m_step <= 7 && overflow) begin
            m_busy = 1'b0; m_err = 1'b1;
        end else if (m_step == 8) begin
            m_busy = 1'b0; m_err = 1'b0;
        end else begin
            m_step++;
        end
    endtask

    task automatic cyc(input logic dr, input logic ov, input logic ok);
        data_ready    = dr;
        overflow      = ov;
        one_k_samples = ok;
        compare_outputs();
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Single sample with one_k asserted so DONE is observed with clear
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 1'b1);
        check_val("single_cnt_up_count", cu_cycles.size(), 1);

        // Withdrawn sample then recovery
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);

        // Overflow in ADD2
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check_val("ovf_err_model", int'(m_err), 1);

        // Continuous input: three passes, cnt_up spaced 10 cycles
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        cu_cycles.delete();
        repeat (30) cyc(1'b1, 1'b0, 1'b0);
        check_val("cont_cnt_up_count", cu_cycles.size(), 3);
        for (int i = 1; i < cu_cycles.size(); i++)
            check_val("cont_cnt_up_spacing", cu_cycles[i] - cu_cycles[i-1], 10);
        repeat (12) cyc(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SH2
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("pre_reset_op_sh2", int'(op), 1);
        #2;
        n_reset = 1'b0;
        #1;
        check_val("rst_op", int'(op), 0);
        check_val("rst_modwait", int'(modwait), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_cnt_up", int'(cnt_up), 0);
        m_busy = 1'b0; m_step = 0; m_err = 1'b0;
        #2;
        n_reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
